// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;

  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/data_mem_array.sv
// rtl/data_mem_array.sv - single-port word RAM, synchronous write and read, no reset
module data_mem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DMEM_DATA_W-1:0] wdata,
  output logic [DMEM_DATA_W-1:0] rdata
);

  logic [DMEM_DATA_W-1:0] mem [2**ADDR_W];

  // Contents survive reset; read data is registered every cycle from the current address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - MEM-stage data-memory responder with fixed access latency
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  input  logic                   req_write,
  input  logic [31:0]            req_addr,
  input  logic [DMEM_DATA_W-1:0] req_wdata,
  output logic                   req_ready,
  output logic                   resp_valid,
  output logic [DMEM_DATA_W-1:0] resp_rdata,
  output logic                   resp_err,
  output logic                   stall
);

  dmem_state_t            state;
  logic [DMEM_CNT_W-1:0]  cnt;
  logic                   hold_write;
  logic [ADDR_W-1:0]      hold_idx;
  logic [DMEM_DATA_W-1:0] hold_wdata;

  logic [ADDR_W-1:0]      req_idx;
  logic                   addr_err;
  logic [ADDR_W-1:0]      ram_addr;
  logic                   ram_we;
  logic [DMEM_DATA_W-1:0] ram_rdata;

  assign req_idx  = req_addr[ADDR_W+1:2];
  assign addr_err = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_W+2] != '0);

  // In IDLE the RAM already reads the incoming index, so read data is valid
  // from the first WAIT cycle even when LATENCY is 1.
  assign ram_addr = (state == IDLE) ? req_idx : hold_idx;
  assign ram_we   = (state == WAIT) && (cnt == '0) && hold_write;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign stall      = ((state == IDLE) && req_valid) || (state == WAIT);

  data_mem_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(hold_wdata),
    .rdata(ram_rdata)
  );

  // Request capture, latency countdown and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      hold_write <= 1'b0;
      hold_idx   <= '0;
      hold_wdata <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            hold_write <= req_write;
            hold_idx   <= req_idx;
            hold_wdata <= req_wdata;
            if (addr_err) begin
              resp_err <= 1'b1;
              state    <= RESP;
            end else begin
              cnt   <= DMEM_CNT_W'(LATENCY - 1);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            if (!hold_write) begin
              resp_rdata <= ram_rdata;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder (LATENCY 2 and 1 builds)
module tb_data_mem_responder;

  typedef struct {
    int          acc;
    int          due;
    bit          err;
    logic [31:0] rdata;
    bit          chk;
  } exp_t;

  logic              clk;
  logic [1:0]        rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_write;
  logic [1:0][31:0]  req_addr;
  logic [1:0][31:0]  req_wdata;
  logic [1:0]        rdy;
  logic [1:0]        rv;
  logic [1:0][31:0]  rdata;
  logic [1:0]        err;
  logic [1:0]        stall;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] model_mem [int];

  data_mem_responder #(.ADDR_W(8), .LATENCY(2)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_ready(rdy[0]),
    .resp_valid(rv[0]), .resp_rdata(rdata[0]), .resp_err(err[0]), .stall(stall[0])
  );

  data_mem_responder #(.ADDR_W(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_ready(rdy[1]),
    .resp_valid(rv[1]), .resp_rdata(rdata[1]), .resp_err(err[1]), .stall(stall[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qfront(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpop(input int i);
    if (i == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic qpush(input int i, input exp_t e);
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor for one instance: outstanding request decides ready/stall/response.
  task automatic check_inst(input int i);
    exp_t h;
    bit   have;
    bit   busy;
    bit   in_resp;
    have    = (qsize(i) > 0);
    busy    = 1'b0;
    in_resp = 1'b0;
    if (have) begin
      h       = qfront(i);
      busy    = (cyc > h.acc) && (cyc <= h.due);
      in_resp = (cyc == h.due);
    end
    chk1($sformatf("req_ready[%0d]", i), rdy[i], !busy);
    chk1($sformatf("stall[%0d]", i), stall[i], in_resp ? 1'b0 : (busy ? 1'b1 : req_valid[i]));
    chk1($sformatf("resp_valid[%0d]", i), rv[i], in_resp);
    if (in_resp) begin
      chk1($sformatf("resp_err[%0d]", i), err[i], h.err);
      if (h.chk) chk32($sformatf("resp_rdata[%0d]", i), rdata[i], h.rdata);
      qpop(i);
    end else if (!rv[i]) begin
      chk1($sformatf("idle_err[%0d]", i), err[i], 1'b0);
      chk32($sformatf("idle_rdata[%0d]", i), rdata[i], 32'h0);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      check_inst(0);
      check_inst(1);
    end
  end

  // Issue one request; the expected response is computed from the memory model at acceptance.
  task automatic do_req(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input bit hold, output int acc);
    exp_t e;
    bit   bad;
    int   key;
    int   n;
    @(negedge clk);
    req_valid[i] = 1'b1;
    req_write[i] = w;
    req_addr[i]  = a;
    req_wdata[i] = d;
    n = 0;
    while (!rdy[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    if (!rdy[i]) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout[%0d]: req_ready stayed %b, required 1", i, rdy[i]);
      req_valid[i] = 1'b0;
      return;
    end
    bad     = (a[1:0] != 2'b00) || (a[31:10] != 22'h0);
    key     = i * 4096 + int'(a[9:2]);
    e.acc   = cyc;
    e.err   = bad;
    e.due   = cyc + (bad ? 1 : lat_of(i) + 1);
    e.rdata = 32'h0;
    e.chk   = 1'b1;
    if (!bad) begin
      if (w) model_mem[key] = d;
      else if (model_mem.exists(key)) e.rdata = model_mem[key];
      else e.chk = 1'b0;
    end
    qpush(i, e);
    @(posedge clk);
    #1;
    if (!hold) req_valid[i] = 1'b0;
  endtask

  task automatic drain(input int i);
    int n;
    n = 0;
    while (qsize(i) != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (qsize(i) != 0) begin
      errors++;
      checks++;
      $display("FAIL drain_timeout[%0d]: %0d responses outstanding, required 0", i, qsize(i));
    end
  endtask

  task automatic run_random(input int i, input int count);
    logic [31:0] a;
    int          r;
    int          acc;
    bit          hold;
    for (int n = 0; n < count; n++) begin
      r = int'($urandom_range(0, 9));
      a = 32'($urandom_range(0, 15)) << 2;
      if (r == 0) a = a | 32'($urandom_range(1, 3));
      if (r == 1) a = a | (32'h400 << $urandom_range(0, 21));
      if (r == 2) a = 32'h3FC;
      hold = 1'($urandom_range(0, 1));
      do_req(i, 1'($urandom_range(0, 1)), a, $urandom, hold, acc);
      if (!hold) repeat (int'($urandom_range(0, 2))) @(negedge clk);
    end
    @(negedge clk);
    req_valid[i] = 1'b0;
    drain(i);
  endtask

  initial begin
    int a1;
    int a2;
    rst_n     = 2'b00;
    req_valid = 2'b00;
    req_write = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(negedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      chk1("rst_ready", rdy[i], 1'b1);
      chk1("rst_resp_valid", rv[i], 1'b0);
      chk32("rst_rdata", rdata[i], 32'h0);
      chk1("rst_err", err[i], 1'b0);
      chk1("rst_stall", stall[i], 1'b0);
    end
    @(negedge clk);
    rst_n = 2'b11;

    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, a1);
    drain(0);
    do_req(0, 1'b0, 32'h10, 32'h0, 1'b0, a1);
    drain(0);
    do_req(0, 1'b1, 32'h13, 32'h0, 1'b0, a1);
    drain(0);
    do_req(0, 1'b0, 32'h10, 32'h0, 1'b0, a1);
    drain(0);
    do_req(0, 1'b0, 32'h400, 32'h0, 1'b0, a1);
    drain(0);
    do_req(0, 1'b1, 32'h3FC, 32'hCAFEF00D, 1'b0, a1);
    drain(0);
    do_req(0, 1'b0, 32'h3FC, 32'h0, 1'b0, a1);
    drain(0);

    do_req(0, 1'b1, 32'h20, 32'hAAAA5555, 1'b0, a1);
    drain(0);
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 32'h20;
    req_wdata[0] = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b0;
    #2;
    chk1("midwait_rst_valid", rv[0], 1'b0);
    chk1("midwait_rst_ready", rdy[0], 1'b1);
    chk1("midwait_rst_stall", stall[0], 1'b0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    repeat (4) @(negedge clk);
    do_req(0, 1'b0, 32'h20, 32'h0, 1'b0, a1);
    drain(0);

    do_req(0, 1'b0, 32'h10, 32'h0, 1'b1, a1);
    req_addr[0] = 32'h3FC;
    do_req(0, 1'b0, 32'h3FC, 32'h0, 1'b0, a2);
    chk32("b2b_spacing", 32'(a2 - a1), 32'd4);
    drain(0);

    run_random(0, 150);

    do_req(1, 1'b1, 32'h8, 32'h5A5A0F0F, 1'b0, a1);
    drain(1);
    do_req(1, 1'b0, 32'h8, 32'h0, 1'b1, a1);
    do_req(1, 1'b0, 32'h8, 32'h0, 1'b0, a2);
    chk32("b2b_spacing_lat1", 32'(a2 - a1), 32'd3);
    drain(1);
    run_random(1, 60);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
